// File: rtl/imm_pkg.sv
// -----------------------------------------------------------------------------
// imm_pkg
// Shared definitions for the RV immediate generator pipeline:
//   - major opcode constants that carry an immediate
//   - the format code enum reported on out_fmt
//   - the FIFO entry struct {imm, fmt, illegal, tag}
//   - helper functions for opcode classification and immediate assembly
// The entry struct is sized for the widest supported configuration
// (64-bit immediate, up to 32-bit tag). Instances narrow it to their own
// XLEN/TAG_W before buffering.
// -----------------------------------------------------------------------------
package imm_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam int IMM_MAX_W = 64;
    localparam int TAG_MAX_W = 32;

    typedef enum logic [2:0] {
        FMT_I    = 3'd0,
        FMT_S    = 3'd1,
        FMT_B    = 3'd2,
        FMT_U    = 3'd3,
        FMT_J    = 3'd4,
        FMT_NONE = 3'd7
    } imm_fmt_e;

    typedef struct packed {
        logic [IMM_MAX_W-1:0] imm;
        imm_fmt_e             fmt;
        logic                 illegal;
        logic [TAG_MAX_W-1:0] tag;
    } imm_entry_t;

    // Maps the major opcode to its immediate format; anything not listed is
    // reported as having no immediate (and therefore illegal for this block).
    function automatic imm_fmt_e opcodeToFmt(input logic [6:0] opcode);
        imm_fmt_e fmt;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt = FMT_I;
            OPC_STORE:                      fmt = FMT_S;
            OPC_BRANCH:                     fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:             fmt = FMT_U;
            OPC_JAL:                        fmt = FMT_J;
            default:                        fmt = FMT_NONE;
        endcase
        return fmt;
    endfunction

    // Assembles the 64-bit sign-extended immediate. Only instruction bits
    // [31:7] carry immediate fields, so the opcode bits are not passed in.
    // Narrower XLEN simply keeps the low bits, which is still a correct
    // sign extension from bit 31.
    function automatic logic [IMM_MAX_W-1:0] buildImm(input logic [31:7] instrHi,
                                                      input imm_fmt_e    fmt);
        logic [IMM_MAX_W-1:0] imm;
        imm = '0;
        case (fmt)
            FMT_I: imm = {{53{instrHi[31]}}, instrHi[30:20]};
            FMT_S: imm = {{53{instrHi[31]}}, instrHi[30:25], instrHi[11:7]};
            FMT_B: imm = {{52{instrHi[31]}}, instrHi[7], instrHi[30:25],
                          instrHi[11:8], 1'b0};
            FMT_U: imm = {{33{instrHi[31]}}, instrHi[30:12], 12'b0};
            FMT_J: imm = {{44{instrHi[31]}}, instrHi[19:12], instrHi[20],
                          instrHi[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/imm_skid_fifo.sv
// -----------------------------------------------------------------------------
// imm_skid_fifo
// Two-entry valid/ready FIFO with a generic payload.
//   clk          : clock, all state on rising edge
//   rst_n        : synchronous active-low reset, empties the FIFO
//   i_in_valid   : producer offers i_in_data
//   o_in_ready   : FIFO can take an entry (registered occupancy only, held
//                  low while reset is asserted)
//   i_in_data    : payload to store
//   o_out_valid  : head entry is presented on o_out_data
//   i_out_ready  : consumer takes the head entry
//   o_out_data   : head entry, stable until consumed
// -----------------------------------------------------------------------------
module imm_skid_fifo #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wrPtr;
    logic              r_rdPtr;
    logic [1:0]        r_count;
    logic              w_push;
    logic              w_pop;

    // Ready is a function of stored occupancy only, so a stalled consumer
    // never creates a combinational path back to the producer.
    assign o_in_ready  = rst_n && (r_count != 2'd2);
    assign o_out_valid = (r_count != 2'd0);
    assign o_out_data  = r_mem[r_rdPtr];

    assign w_push = i_in_valid & o_in_ready;
    assign w_pop  = o_out_valid & i_out_ready;

    // Storage, pointers and occupancy. Storage is cleared on reset so the
    // head reads as all-zero until the first entry arrives. A push and pop
    // in the same cycle at occupancy 1 hands the new entry straight to head.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wrPtr  <= 1'b0;
            r_rdPtr  <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr] <= i_in_data;
                r_wrPtr        <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 2'd1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 2'd1;
            end
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
// Decodes the immediate of an RV instruction and buffers the result in a
// 2-entry FIFO together with a sideband tag.
//   clk, rst_n   : clock and synchronous active-low reset
//   in_valid/in_ready, in_instr, in_tag     : instruction input handshake
//   out_valid/out_ready, out_imm, out_fmt,
//   out_illegal, out_tag                    : decoded result handshake
//   err_count    : saturating count of accepted illegal opcodes
// Parameters: XLEN (32 or 64), TAG_W (1..32), CNT_W.
// -----------------------------------------------------------------------------
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] err_count
);

    localparam int PAY_W = XLEN + 3 + 1 + TAG_W;

    imm_fmt_e         w_fmt;
    imm_entry_t       w_entry;
    logic [PAY_W-1:0] w_pushData;
    logic [PAY_W-1:0] w_popData;
    logic             w_inFire;
    logic [CNT_W-1:0] r_errCount;

    assign w_fmt = opcodeToFmt(in_instr[6:0]);

    // Combinational decode of the offered instruction into a full-width
    // entry; illegal opcodes get a zero immediate from buildImm's default.
    always_comb begin
        w_entry         = '0;
        w_entry.imm     = buildImm(in_instr[31:7], w_fmt);
        w_entry.fmt     = w_fmt;
        w_entry.illegal = (w_fmt == FMT_NONE);
        w_entry.tag     = TAG_MAX_W'(in_tag);
    end

    // Only the bits this instance actually presents are buffered.
    assign w_pushData = {w_entry.imm[XLEN-1:0], w_entry.fmt,
                         w_entry.illegal, w_entry.tag[TAG_W-1:0]};

    generate
        if (XLEN < IMM_MAX_W) begin : g_immTrim
            logic [IMM_MAX_W-XLEN-1:0] w_unusedImmHi;
            assign w_unusedImmHi = w_entry.imm[IMM_MAX_W-1:XLEN];
        end
        if (TAG_W < TAG_MAX_W) begin : g_tagTrim
            logic [TAG_MAX_W-TAG_W-1:0] w_unusedTagHi;
            assign w_unusedTagHi = w_entry.tag[TAG_MAX_W-1:TAG_W];
        end
    endgenerate

    imm_skid_fifo #(
        .DATA_W (PAY_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (w_pushData),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (w_popData)
    );

    assign out_imm     = w_popData[PAY_W-1 -: XLEN];
    assign out_fmt     = w_popData[TAG_W+1 +: 3];
    assign out_illegal = w_popData[TAG_W];
    assign out_tag     = w_popData[TAG_W-1:0];

    assign w_inFire = in_valid & in_ready;

    // Counts accepted illegal opcodes and sticks at all-ones instead of
    // wrapping, so a large count is never mistaken for a small one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_errCount <= '0;
        end else if (w_inFire && w_entry.illegal &&
                     (r_errCount != {CNT_W{1'b1}})) begin
            r_errCount <= r_errCount + 1'b1;
        end
    end

    assign err_count = r_errCount;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
// Drives two instances side by side (XLEN=32/CNT_W=16 and XLEN=64/CNT_W=2)
// with identical stimulus. Accepted instructions push an expected result into
// a scoreboard queue; a monitor compares the head entry, handshake signals and
// error counters every cycle and pops on each output transfer.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [7:0]  in_tag = '0;

    logic        in_ready32, out_valid32, out_ill32;
    logic [31:0] out_imm32;
    logic [2:0]  out_fmt32;
    logic [7:0]  out_tag32;
    logic [15:0] err32;

    logic        in_ready64, out_valid64, out_ill64;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt64;
    logic [7:0]  out_tag64;
    logic [1:0]  err64;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [7:0]  tag;
    } exp_t;

    exp_t expQ[$];
    int   checkCount = 0;
    int   passCount = 0;
    int   errModel32 = 0;
    int   errModel64 = 0;
    bit   monitorOn = 0;
    bit   freshReset = 0;
    bit   fire = 0;
    int   outReadyMode = 1;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8), .CNT_W(16)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid32),
        .out_ready(out_ready), .out_imm(out_imm32), .out_fmt(out_fmt32),
        .out_illegal(out_ill32), .out_tag(out_tag32), .err_count(err32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8), .CNT_W(2)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid64),
        .out_ready(out_ready), .out_imm(out_imm64), .out_fmt(out_fmt64),
        .out_illegal(out_ill64), .out_tag(out_tag64), .err_count(err64)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference decode using arithmetic on the sign-extended word.
    function automatic exp_t refDecode(input logic [31:0] ins, input logic [7:0] tag);
        exp_t       e;
        longint     s;
        logic [6:0] op;
        s = longint'($signed(ins));
        op = ins[6:0];
        e.tag = tag;
        e.ill = 1'b0;
        e.fmt = 3'd0;
        e.imm = '0;
        case (op)
            7'b0010011, 7'b0000011, 7'b1100111: begin
                e.fmt = 3'd0;
                e.imm = s >>> 20;
            end
            7'b0100011: begin
                e.fmt = 3'd1;
                e.imm = ((s >>> 25) <<< 5) | longint'(ins[11:7]);
            end
            7'b1100011: begin
                e.fmt = 3'd2;
                e.imm = ((s >>> 31) <<< 12) | (longint'(ins[7]) << 11) |
                        (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
            end
            7'b0110111, 7'b0010111: begin
                e.fmt = 3'd3;
                e.imm = s & ~longint'(12'hFFF);
            end
            7'b1101111: begin
                e.fmt = 3'd4;
                e.imm = ((s >>> 31) <<< 20) | (longint'(ins[19:12]) << 12) |
                        (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
            end
            default: begin
                e.fmt = 3'd7;
                e.ill = 1'b1;
                e.imm = '0;
            end
        endcase
        return e;
    endfunction

    task automatic applyStimulus(input logic [31:0] ins, input logic [7:0] tag,
                                 input bit known, input logic [63:0] kImm,
                                 input logic [2:0] kFmt);
        exp_t e;
        bit   accepted = 0;
        if (known) begin
            e.imm = kImm;
            e.fmt = kFmt;
            e.ill = (kFmt == 3'd7);
            e.tag = tag;
        end else begin
            e = refDecode(ins, tag);
        end
        @(negedge clk);
        #1;
        in_valid = 1'b1;
        in_instr = ins;
        in_tag   = tag;
        for (int w = 0; w < 20 && !accepted; w++) begin
            #2;
            if (in_ready32) accepted = 1;
            @(posedge clk);
            if (!accepted) begin
                @(negedge clk);
                #1;
            end
        end
        if (accepted) begin
            expQ.push_back(e);
            freshReset = 0;
            if (e.ill) begin
                if (errModel32 < 65535) errModel32++;
                if (errModel64 < 3) errModel64++;
            end
        end else begin
            checkCount++;
            $display("[TB] FAIL accept_timeout: instr 0x%08h not accepted, required within 20 cycles", ins);
            in_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        expQ.delete();
        errModel32 = 0;
        errModel64 = 0;
        freshReset = 1;
        monitorOn = 1;
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compare everything visible at the falling edge, pick
    // out_ready, then pop the scoreboard on the following output transfer.
    initial begin
        logic expRdy;
        logic expVld;
        forever begin
            @(negedge clk);
            if (monitorOn) begin
                expRdy = rst_n && (expQ.size() < 2);
                expVld = (expQ.size() > 0);
                checkOutput("in_ready32", 64'(in_ready32), 64'(expRdy));
                checkOutput("in_ready64", 64'(in_ready64), 64'(expRdy));
                checkOutput("out_valid32", 64'(out_valid32), 64'(expVld));
                checkOutput("out_valid64", 64'(out_valid64), 64'(expVld));
                checkOutput("err_count32", 64'(err32), 64'(errModel32));
                checkOutput("err_count64", 64'(err64), 64'(errModel64));
                if (out_valid32 && expQ.size() > 0) begin
                    checkOutput("imm32", 64'(out_imm32), 64'(expQ[0].imm[31:0]));
                    checkOutput("fmt32", 64'(out_fmt32), 64'(expQ[0].fmt));
                    checkOutput("illegal32", 64'(out_ill32), 64'(expQ[0].ill));
                    checkOutput("tag32", 64'(out_tag32), 64'(expQ[0].tag));
                    checkOutput("imm64", out_imm64, expQ[0].imm);
                    checkOutput("fmt64", 64'(out_fmt64), 64'(expQ[0].fmt));
                    checkOutput("illegal64", 64'(out_ill64), 64'(expQ[0].ill));
                    checkOutput("tag64", 64'(out_tag64), 64'(expQ[0].tag));
                end else if (!out_valid32 && freshReset) begin
                    checkOutput("reset_imm32", 64'(out_imm32), 64'd0);
                    checkOutput("reset_fmt32", 64'(out_fmt32), 64'd0);
                    checkOutput("reset_illegal32", 64'(out_ill32), 64'd0);
                    checkOutput("reset_tag32", 64'(out_tag32), 64'd0);
                    checkOutput("reset_imm64", out_imm64, 64'd0);
                    checkOutput("reset_tag64", 64'(out_tag64), 64'd0);
                end
            end
            case (outReadyMode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            fire = monitorOn && out_valid32 && out_ready;
            @(posedge clk);
            if (fire && rst_n && expQ.size() > 0) void'(expQ.pop_front());
        end
    end

    logic [31:0] dirInstr [10] = '{32'hFFF00093, 32'hFE20AE23, 32'h12345037,
                                   32'h0010006F, 32'h80000037, 32'hFE000FE3,
                                   32'h7FF00067, 32'h80002003, 32'h00001017,
                                   32'h00000000};
    logic [63:0] dirImm [10] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC,
                                 64'h0000000012345000, 64'h0000000000000800,
                                 64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFE,
                                 64'h00000000000007FF, 64'hFFFFFFFFFFFFF800,
                                 64'h0000000000001000, 64'h0000000000000000};
    logic [2:0]  dirFmt [10] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd3, 3'd2, 3'd0,
                                 3'd0, 3'd3, 3'd7};
    logic [31:0] badInstr [5] = '{32'h00000000, 32'h0000007F, 32'h0000000B,
                                  32'hFFFFFFFF, 32'h12345601};
    logic [6:0]  legalOps [8] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                                  7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};

    initial begin
        logic [31:0] r;
        logic [31:0] ins;
        int          sel;
        doReset();

        // Directed vectors, back to back, consumer always ready.
        outReadyMode = 1;
        for (int k = 0; k < 10; k++)
            applyStimulus(dirInstr[k], 8'(8'h11 + k), 1, dirImm[k], dirFmt[k]);
        idle(3);

        // Illegal opcodes: counter climbs on one instance, saturates at 3 on the other.
        for (int k = 0; k < 5; k++)
            applyStimulus(badInstr[k], 8'(8'hA0 + k), 1, 64'd0, 3'd7);
        idle(3);

        // Backpressure: three offers against a stalled consumer.
        outReadyMode = 0;
        fork
            begin
                for (int k = 0; k < 3; k++)
                    applyStimulus(dirInstr[k], 8'(8'h40 + k), 1, dirImm[k], dirFmt[k]);
            end
            begin
                repeat (8) @(negedge clk);
                outReadyMode = 1;
            end
        join
        idle(4);

        // Reset with two entries buffered, then a single post-reset instruction.
        outReadyMode = 0;
        applyStimulus(32'h00000000, 8'h55, 1, 64'd0, 3'd7);
        applyStimulus(32'h12345037, 8'h56, 1, 64'h0000000012345000, 3'd3);
        idle(2);
        doReset();
        outReadyMode = 1;
        applyStimulus(32'hFFF00093, 8'h11, 1, 64'hFFFFFFFFFFFFFFFF, 3'd0);
        idle(3);

        // Randomized traffic with random consumer stalls.
        outReadyMode = 2;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                r = $urandom();
                sel = $urandom_range(0, 9);
                if (sel < 8) ins = {r[31:7], legalOps[sel]};
                else ins = r;
                applyStimulus(ins, 8'($urandom()), 0, 64'd0, 3'd0);
            end
        end

        // Drain whatever is still buffered.
        outReadyMode = 1;
        idle(1);
        for (int w = 0; w < 50 && expQ.size() > 0; w++) @(posedge clk);
        if (expQ.size() != 0) begin
            checkCount++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
